// File: rtl/dram_width_bridge.sv
// Bridges 32-bit word requests onto a 16-bit SDRAM controller as one or two half-word transactions.
// Build option: define DRAM_BRIDGE_TIMEOUT_EN to abort a stalled sd_ack wait after TIMEOUT_CYCLES.
module dram_width_bridge #(
  parameter int ADDR_BITS      = 24,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_write_data,
  output logic                 mem_ack,
  output logic [31:0]          mem_read_data,
  output logic                 busy,
  output logic [ADDR_BITS:0]   sd_addr,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic [1:0]           sd_be,
  output logic [15:0]          sd_wdata,
  input  logic                 sd_ack,
  input  logic [15:0]          sd_rdata,
  output logic                 timeout_err
);

  // Handshake: a mem_read_en/mem_write_en pulse is accepted only while busy=0 (otherwise dropped);
  // each sd_rd/sd_wr pulse is followed by exactly one sd_ack, and mem_ack pulses once per accepted request.
  typedef enum logic [2:0] {IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic                 write_q;
  logic [15:0]          lo_q;
  logic [31:0]          rdata_q;
  logic                 timed_out;
  logic                 skip_all, in_req, in_wait, hi_half, drive;

  assign skip_all = write_q && (be_q == 4'b0000);
  assign in_req   = (state == LO_REQ) || (state == HI_REQ);
  assign in_wait  = (state == LO_WAIT) || (state == HI_WAIT);
  assign hi_half  = (state == HI_REQ) || (state == HI_WAIT);
  assign drive    = (in_req || in_wait) && !skip_all;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (mem_write_en && (mem_byte_enable[1:0] == 2'b00) && (mem_byte_enable[3:2] != 2'b00))
          state_next = HI_REQ;
        else if (mem_read_en || mem_write_en)
          state_next = LO_REQ;
      end
      // An all-zero write passes through LO_REQ silently so its ack lands two cycles after the request.
      LO_REQ:  state_next = skip_all ? DONE : LO_WAIT;
      LO_WAIT: begin
        if (sd_ack)
          state_next = (write_q && (be_q[3:2] == 2'b00)) ? DONE : HI_REQ;
        else if (timed_out)
          state_next = DONE;
      end
      HI_REQ:  state_next = HI_WAIT;
      HI_WAIT: if (sd_ack || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && (mem_read_en || mem_write_en)) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_write_data;
        be_q    <= mem_byte_enable;
        write_q <= mem_write_en;
      end
      // Low half is parked so mem_read_data only changes when the whole word is complete.
      if (!write_q && sd_ack) begin
        if (state == LO_WAIT) lo_q <= sd_rdata;
        if (state == HI_WAIT) rdata_q <= {sd_rdata, lo_q};
      end
      if (timed_out && !write_q) rdata_q <= 32'hDEADBEEF;
    end
  end

`ifdef DRAM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
      if (timed_out) timeout_q <= 1'b1;
    end
  end

  assign timed_out   = in_wait && !sd_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;
`else
  // TIMEOUT_CYCLES has no effect in this build; the check only keeps the parameter referenced.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign sd_addr       = drive ? {addr_q, hi_half} : '0;
  assign sd_rd         = in_req && !write_q;
  assign sd_wr         = in_req && write_q && !skip_all;
  assign sd_be         = !drive  ? 2'b00 :
                         !write_q ? 2'b11 :
                         hi_half  ? be_q[3:2] : be_q[1:0];
  assign sd_wdata      = (drive && write_q) ? (hi_half ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign mem_ack       = (state == DONE);
  assign busy          = (state != IDLE);
  assign mem_read_data = rdata_q;

endmodule

// File: doc/dram_width_bridge.md
Name: dram_width_bridge

Overview:
- Sits between the MCU external DRAM port and a 16-bit SDRAM controller.
- Converts each 32-bit word request (read, or byte-enabled write) into one or two 16-bit half-word transactions.
- Returns a single-cycle ack to the MCU, with the reassembled 32-bit read data on reads.
- Owns no storage beyond a one-request holding register; only one request is in flight at a time.

Parameters:
- ADDR_BITS, 24, width of the upstream 32-bit word address; downstream half-word address is ADDR_BITS+1.
- TIMEOUT_CYCLES, 1023, cycles to wait for sd_ack before abort. Used only with DRAM_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  single clock
- sync_reset  in  1  synchronous reset, active-high
- mem_addr  in  ADDR_BITS  word address, sampled on request
- mem_read_en  in  1  one-cycle read request pulse
- mem_write_en  in  1  one-cycle write request pulse
- mem_byte_enable  in  4  byte lanes for write; bit0 = bits[7:0]
- mem_write_data  in  32  write word, sampled on request
- mem_ack  out  1  one-cycle completion pulse
- mem_read_data  out  32  read word, valid when mem_ack=1
- busy  out  1  request held, state != IDLE
- sd_addr  out  ADDR_BITS+1  half-word address = {word_addr, half}
- sd_rd  out  1  one-cycle half-word read pulse
- sd_wr  out  1  one-cycle half-word write pulse
- sd_be  out  2  half-word byte enables
- sd_wdata  out  16  half-word write data
- sd_ack  in  1  downstream completion pulse; sd_rdata valid on reads
- sd_rdata  in  16  half-word read data
- timeout_err  out  1  sticky timeout flag; tied 0 without the feature

Behaviour:
- Reset (sync_reset=1 at a clk edge): state=IDLE and all outputs 0, including mem_read_data and timeout_err.
  - Reset is honoured mid-transaction: the held request is discarded, no mem_ack is issued, and a later stray sd_ack is ignored.
- States: IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE.
- IDLE:
  - Request accepted on mem_read_en|mem_write_en; latch addr, data, be and op.
  - If both enables are high, the request is treated as a write.
  - sd_ack in IDLE is ignored.
- Half-word split:
  - Low half: half=0, data[15:0], be[1:0]. High half: half=1, data[31:16], be[3:2].
  - Read: both halves, always low then high; sd_be=2'b11.
  - Write: a half with zero enables is skipped.
    - Low skipped: go directly to HI_REQ.
    - High skipped: go from LO_WAIT to DONE.
    - be=4'b0000: IDLE -> DONE; mem_ack 2 cycles after the request, no sd traffic.
- LO_REQ / HI_REQ: drive sd_rd or sd_wr for exactly one cycle with sd_addr/sd_be/sd_wdata, then enter *_WAIT.
  - sd_addr/sd_be/sd_wdata stay stable through *_WAIT.
- LO_WAIT / HI_WAIT:
  - Hold until sd_ack.
  - On a read, capture sd_rdata into the corresponding 16-bit half of mem_read_data.
  - An sd_ack in the same cycle as the sd_rd/sd_wr pulse is not legal downstream and need not be handled.
- DONE: mem_ack=1 for one cycle, then IDLE. mem_read_data holds its value until the next read completes.
- Latency, read with downstream ack latency L (ack L cycles after the pulse, L>=1):
  - request at cycle 0, sd_rd low at cycle 1, high at cycle L+2, mem_ack at cycle 2L+3.
- Requests while busy=1 are dropped silently. busy is a protocol violation indicator only.
- Order guarantee: the low half is always issued before the high half; never concurrent.

Optional Feature:
- Macro: DRAM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter in LO_WAIT/HI_WAIT is cleared on entry to each wait state.
  - If it reaches TIMEOUT_CYCLES with no sd_ack, go to DONE.
  - In that case mem_ack still pulses; a read returns 32'hDEADBEEF; timeout_err sets and stays set until sync_reset.
- Undefined: no counter; the wait is unbounded; timeout_err is constant 0.

Test Plan:
- Read addr 0x000010, sd_ack latency 1, sd_rdata 0x5678 then 0x1234 -> sd_addr 0x000020 then 0x000021, sd_be=3; mem_read_data=0x12345678 with mem_ack at cycle 5.
- Write 0xAABBCCDD, be=4'b1111, addr 0x3 -> two sd_wr: addr 0x6 data 0xCCDD be 3, then addr 0x7 data 0xAABB be 3; one mem_ack.
- Write be=4'b1100 -> single sd_wr addr odd, sd_be=3, data [31:16]. Then be=4'b0001 -> single sd_wr addr even, sd_be=1.
- Write be=0 -> no sd_wr/sd_rd; mem_ack 2 cycles after the request. A second request issued during busy -> no extra mem_ack.
- sync_reset asserted while in LO_WAIT, then sd_ack arrives -> no mem_ack, all outputs 0, busy=0, next read completes normally.
- Feature on, TIMEOUT_CYCLES=8, sd_ack never returns on a read -> mem_ack after 8 wait cycles, data 0xDEADBEEF, timeout_err=1 held until reset.
